pulse_arbiter: RTL and testbench

PULSE_ARBITER -- requirements
Module: pulse_arbiter

---
 rtl/pulse_arbiter.sv | 125 ++++++++++++
 tb/tb_pulse_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_arbiter.sv
// Two-producer pulse arbiter: grants one dav/rfd channel at a time and emits a
// single pulse on out whose length is the granted channel's data word.
module pulse_arbiter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         dav_x,
  input  logic [W-1:0] x,
  output logic         rfd_x,
  input  logic         dav_y,
  input  logic [W-1:0] y,
  output logic         rfd_y,
  output logic         out,
  output logic         src
);

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [1:0]   state_reg, state_next;
  logic [W-1:0] cnt_reg, cnt_next;
  logic         out_reg, out_next;
  logic         rfd_x_reg, rfd_x_next;
  logic         rfd_y_reg, rfd_y_next;
  logic         src_reg, src_next;
  logic         last_reg, last_next;

  logic         any_req;
  logic         grant_y;
  logic [W-1:0] grant_data;
  logic         granted_dav;

  // On a tie, Y wins only if X was the channel served last.
  assign any_req     = ~dav_x | ~dav_y;
  assign grant_y     = ~dav_y & (dav_x | ~last_reg);
  assign grant_data  = grant_y ? y : x;
  assign granted_dav = src_reg ? dav_y : dav_x;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    rfd_x_next = rfd_x_reg;
    rfd_y_next = rfd_y_reg;
    src_next   = src_reg;
    last_next  = last_reg;

    case (state_reg)
      ST_WAIT: begin
        out_next   = 1'b0;
        rfd_x_next = 1'b1;
        rfd_y_next = 1'b1;
        if (any_req) begin
          // A zero-length request still produces a one-cycle pulse.
          cnt_next   = (grant_data == '0) ? CNT_ONE : grant_data;
          src_next   = grant_y;
          out_next   = 1'b1;
          state_next = ST_PULSE;
          if (grant_y) begin
            rfd_y_next = 1'b0;
          end else begin
            rfd_x_next = 1'b0;
          end
        end
      end

      ST_PULSE: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          out_next   = 1'b0;
          state_next = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (granted_dav) begin
          if (src_reg) begin
            rfd_y_next = 1'b1;
          end else begin
            rfd_x_next = 1'b1;
          end
          last_next  = src_reg;
          state_next = ST_WAIT;
        end
      end

      default: begin
        out_next   = 1'b0;
        rfd_x_next = 1'b1;
        rfd_y_next = 1'b1;
        state_next = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_reg <= ST_WAIT;
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
      rfd_x_reg <= 1'b1;
      rfd_y_reg <= 1'b1;
      src_reg   <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      rfd_x_reg <= rfd_x_next;
      rfd_y_reg <= rfd_y_next;
      src_reg   <= src_next;
      last_reg  <= last_next;
    end
  end

  assign out   = out_reg;
  assign rfd_x = rfd_x_reg;
  assign rfd_y = rfd_y_reg;
  assign src   = src_reg;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed bench for pulse_arbiter: each task drives one scenario and checks
// pulse widths, gaps, ownership and handshake timing against hand-computed values.
module tb_pulse_arbiter;

  localparam int W = 8;

  logic         clock;
  logic         reset_;
  logic         dav_x;
  logic [W-1:0] x;
  logic         rfd_x;
  logic         dav_y;
  logic [W-1:0] y;
  logic         rfd_y;
  logic         out;
  logic         src;

  int total = 0;
  int bad   = 0;

  pulse_arbiter #(.W(W)) dut (
    .clock (clock),
    .reset_(reset_),
    .dav_x (dav_x),
    .x     (x),
    .rfd_x (rfd_x),
    .dav_y (dav_y),
    .y     (y),
    .rfd_y (rfd_y),
    .out   (out),
    .src   (src)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Bounded measurement from the current negedge: low cycles before the
  // pulse, then high cycles. Returns at the first negedge with out low.
  task automatic measure_pulse(output int gap, output int width, output logic s);
    gap   = 0;
    width = 0;
    s     = 1'bx;
    while (!out && gap < 100) begin
      @(negedge clock);
      gap++;
    end
    s = src;
    while (out && width < 300) begin
      width++;
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_ = 1'b0;
    dav_x  = 1'b1;
    dav_y  = 1'b1;
    x      = '0;
    y      = '0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    dav_x = 1'b1;
    dav_y = 1'b1;
    x = '0;
    y = '0;
    #2 reset_ = 1'b0;
    #1;
    total++; if (out !== 1'b0)   begin bad++; $display("FAIL reset_out got=%b exp=0", out); end
    total++; if (rfd_x !== 1'b1) begin bad++; $display("FAIL reset_rfd_x got=%b exp=1", rfd_x); end
    total++; if (rfd_y !== 1'b1) begin bad++; $display("FAIL reset_rfd_y got=%b exp=1", rfd_y); end
    total++; if (src !== 1'b0)   begin bad++; $display("FAIL reset_src got=%b exp=0", src); end
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (out !== 1'b0)   begin bad++; $display("FAIL post_reset_out got=%b exp=0", out); end
    total++; if (rfd_x !== 1'b1) begin bad++; $display("FAIL post_reset_rfd_x got=%b exp=1", rfd_x); end
    total++; if (rfd_y !== 1'b1) begin bad++; $display("FAIL post_reset_rfd_y got=%b exp=1", rfd_y); end
    total++; if (src !== 1'b0)   begin bad++; $display("FAIL post_reset_src got=%b exp=0", src); end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    int g, w;
    logic s;
    do_reset();
    x = 8'd15;
    dav_x = 1'b0;
    @(negedge clock);
    total++; if (rfd_x !== 1'b0) begin bad++; $display("FAIL single_rfd_x got=%b exp=0", rfd_x); end
    total++; if (out !== 1'b1)   begin bad++; $display("FAIL single_out got=%b exp=1", out); end
    total++; if (src !== 1'b0)   begin bad++; $display("FAIL single_src got=%b exp=0", src); end
    total++; if (rfd_y !== 1'b1) begin bad++; $display("FAIL single_rfd_y got=%b exp=1", rfd_y); end
    x = 8'd2;
    measure_pulse(g, w, s);
    total++; if (w !== 15) begin bad++; $display("FAIL single_width got=%0d exp=15", w); end
    repeat (3) @(negedge clock);
    total++; if (rfd_x !== 1'b0) begin bad++; $display("FAIL single_hold_rfd_x got=%b exp=0", rfd_x); end
    total++; if (out !== 1'b0)   begin bad++; $display("FAIL single_hold_out got=%b exp=0", out); end
    dav_x = 1'b1;
    @(negedge clock);
    total++; if (rfd_x !== 1'b1) begin bad++; $display("FAIL single_release_rfd_x got=%b exp=1", rfd_x); end
    $display("test_single: width=%0d", w);
  endtask

  task automatic test_tie();
    int g, w;
    logic s;
    do_reset();
    x = 8'd5;
    y = 8'd12;
    dav_x = 1'b0;
    dav_y = 1'b0;
    @(negedge clock);
    dav_x = 1'b1;
    measure_pulse(g, w, s);
    total++; if (w !== 5)    begin bad++; $display("FAIL tie_x_width got=%0d exp=5", w); end
    total++; if (s !== 1'b0) begin bad++; $display("FAIL tie_x_src got=%b exp=0", s); end
    measure_pulse(g, w, s);
    total++; if (g !== 2)    begin bad++; $display("FAIL tie_gap got=%0d exp=2", g); end
    total++; if (w !== 12)   begin bad++; $display("FAIL tie_y_width got=%0d exp=12", w); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL tie_y_src got=%b exp=1", s); end
    dav_y = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (rfd_y !== 1'b1) begin bad++; $display("FAIL tie_rfd_y got=%b exp=1", rfd_y); end
    total++; if (src !== 1'b1)   begin bad++; $display("FAIL tie_src_hold got=%b exp=1", src); end
    $display("test_tie: done");
  endtask

  task automatic test_fairness();
    int widths[$];
    int gaps[$];
    logic srcs[$];
    int exp_w[4];
    logic exp_s[4];
    int w, g;
    logic prev;
    exp_w = '{3, 4, 3, 4};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    x = 8'd3;
    y = 8'd4;
    dav_x = 1'b0;
    dav_y = 1'b0;
    prev = 1'b0;
    w = 0;
    g = 0;
    for (int c = 0; c < 80 && widths.size() < 4; c++) begin
      @(negedge clock);
      if (out) begin
        if (!prev) begin
          srcs.push_back(src);
          gaps.push_back(g);
        end
        w++;
      end else begin
        if (prev) begin
          widths.push_back(w);
          w = 0;
          g = 0;
        end
        g++;
      end
      prev = out;
      // Each producer re-requests as soon as it sees rfd high again.
      dav_x = rfd_x ? 1'b0 : 1'b1;
      dav_y = rfd_y ? 1'b0 : 1'b1;
    end
    total++; if (widths.size() !== 4) begin bad++; $display("FAIL fair_count got=%0d exp=4", widths.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < widths.size()) begin
        total++; if (widths[i] !== exp_w[i]) begin bad++; $display("FAIL fair_width[%0d] got=%0d exp=%0d", i, widths[i], exp_w[i]); end
        total++; if (srcs[i] !== exp_s[i])   begin bad++; $display("FAIL fair_src[%0d] got=%b exp=%b", i, srcs[i], exp_s[i]); end
        if (i > 0) begin
          total++; if (gaps[i] !== 2) begin bad++; $display("FAIL fair_gap[%0d] got=%0d exp=2", i, gaps[i]); end
        end
      end
    end
    dav_x = 1'b1;
    dav_y = 1'b1;
    $display("test_fairness: pulses=%0d", widths.size());
  endtask

  task automatic test_zero();
    int g, w;
    logic s;
    do_reset();
    y = 8'd0;
    dav_y = 1'b0;
    @(negedge clock);
    total++; if (src !== 1'b1)   begin bad++; $display("FAIL zero_src got=%b exp=1", src); end
    total++; if (rfd_y !== 1'b0) begin bad++; $display("FAIL zero_rfd_y got=%b exp=0", rfd_y); end
    dav_y = 1'b1;
    measure_pulse(g, w, s);
    total++; if (w !== 1) begin bad++; $display("FAIL zero_width got=%0d exp=1", w); end
    @(negedge clock);
    total++; if (rfd_y !== 1'b1) begin bad++; $display("FAIL zero_rfd_y_back got=%b exp=1", rfd_y); end
    total++; if (src !== 1'b1)   begin bad++; $display("FAIL zero_src_hold got=%b exp=1", src); end
    $display("test_zero: width=%0d", w);
  endtask

  task automatic test_max();
    int g, w;
    logic s;
    do_reset();
    x = 8'd255;
    dav_x = 1'b0;
    @(negedge clock);
    dav_x = 1'b1;
    measure_pulse(g, w, s);
    total++; if (w !== 255) begin bad++; $display("FAIL max_width got=%0d exp=255", w); end
    $display("test_max: width=%0d", w);
  endtask

  task automatic test_reset_mid();
    int g, w;
    logic s;
    do_reset();
    y = 8'd20;
    dav_y = 1'b0;
    @(negedge clock);
    repeat (6) @(negedge clock);
    total++; if (out !== 1'b1) begin bad++; $display("FAIL mid_pre_out got=%b exp=1", out); end
    #2 reset_ = 1'b0;
    #1;
    total++; if (out !== 1'b0)   begin bad++; $display("FAIL mid_out got=%b exp=0", out); end
    total++; if (rfd_y !== 1'b1) begin bad++; $display("FAIL mid_rfd_y got=%b exp=1", rfd_y); end
    total++; if (src !== 1'b0)   begin bad++; $display("FAIL mid_src got=%b exp=0", src); end
    @(negedge clock);
    dav_y = 1'b1;
    reset_ = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (out !== 1'b0) begin bad++; $display("FAIL mid_after_out got=%b exp=0", out); end
    x = 8'd6;
    y = 8'd9;
    dav_x = 1'b0;
    dav_y = 1'b0;
    @(negedge clock);
    dav_x = 1'b1;
    measure_pulse(g, w, s);
    total++; if (w !== 6)    begin bad++; $display("FAIL mid_x_width got=%0d exp=6", w); end
    total++; if (s !== 1'b0) begin bad++; $display("FAIL mid_x_src got=%b exp=0", s); end
    measure_pulse(g, w, s);
    total++; if (w !== 9)    begin bad++; $display("FAIL mid_y_width got=%0d exp=9", w); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL mid_y_src got=%b exp=1", s); end
    dav_y = 1'b1;
    $display("test_reset_mid: done");
  endtask

  initial begin
    reset_ = 1'b1;
    dav_x  = 1'b1;
    dav_y  = 1'b1;
    x      = '0;
    y      = '0;
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_zero();
    test_max();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
